// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x3 keypad scanner: column drive patterns, key codes,
// FSM state encoding and the column/row to key-code map.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_PRESS_DB = 2'd1,
    ST_HELD     = 2'd2,
    ST_REL_DB   = 2'd3
  } state_e;

  localparam logic [3:0] COL0 = 4'b0111;
  localparam logic [3:0] COL1 = 4'b1011;
  localparam logic [3:0] COL2 = 4'b1101;

  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;

  function automatic logic [3:0] col_pattern(input logic [1:0] col);
    logic [3:0] pat;
    pat = COL0;
    case (col)
      2'd1:    pat = COL1;
      2'd2:    pat = COL2;
      default: pat = COL0;
    endcase
    return pat;
  endfunction

  // Physical layout: column 0 holds 1/4/7/*, column 1 holds 2/5/8/0, column 2 holds 3/6/9/#.
  function automatic logic [3:0] decode_key(input logic [1:0] col, input logic [1:0] row);
    logic [3:0] code;
    code = 4'h0;
    case ({col, row})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h4;
      4'b00_10: code = 4'h7;
      4'b00_11: code = KEY_STAR;
      4'b01_00: code = 4'h2;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h8;
      4'b01_11: code = 4'h0;
      4'b10_00: code = 4'h3;
      4'b10_01: code = 4'h6;
      4'b10_10: code = 4'h9;
      4'b10_11: code = KEY_HASH;
      default:  code = 4'h0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchroniser for the asynchronous, active-low keypad row lines.
module keypad_row_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] rs
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 4'b1111;
      sync_q <= 4'b1111;
    end else begin
      meta_q <= row_in;
      sync_q <= meta_q;
    end
  end

  assign rs = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x3 keypad scan sequencer with press/release debounce and a 4-digit BCD preset register.
// Optional auto-repeat of held digit keys is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int CNT_W        = 20,
  parameter int REPEAT_CYC   = 250000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] digits,
  output logic        enter
);

  if (SCAN_DIV < 2 || DEBOUNCE_CYC < 2 || REPEAT_CYC < 2 ||
      SCAN_DIV > (1 << CNT_W) || DEBOUNCE_CYC > (1 << CNT_W)) begin : g_bad_params
    $error("keypad_scan_ctrl: illegal parameter combination");
  end

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);

  state_e            state_q, state_d;
  logic [1:0]        col_q, col_d;
  logic [1:0]        row_q, row_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              key_valid_q, key_valid_d;
  logic [3:0]        key_code_q, key_code_d;
  logic [15:0]       digits_q, digits_d;
  logic              enter_q, enter_d;

  logic [3:0] rs;
  logic       one_low;
  logic [1:0] row_idx;
  logic [3:0] held_pat;
  logic [1:0] next_col;
  logic       fire;
  logic [3:0] fire_code;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYC);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYC - 1);
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
`endif

  keypad_row_sync u_row_sync (
    .clk    (clk),
    .rst    (rst),
    .row_in (row_in),
    .rs     (rs)
  );

  // Anything other than exactly one low row is treated as no key (ghosting guard).
  always_comb begin
    one_low = 1'b1;
    row_idx = 2'd0;
    case (rs)
      4'b0111: row_idx = 2'd0;
      4'b1011: row_idx = 2'd1;
      4'b1101: row_idx = 2'd2;
      4'b1110: row_idx = 2'd3;
      default: one_low = 1'b0;
    endcase
  end

  assign held_pat  = ~(4'b1000 >> row_q);
  assign next_col  = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
  assign fire_code = decode_key(col_q, row_q);

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    cnt_d       = cnt_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    digits_d    = digits_q;
    enter_d     = 1'b0;
    fire        = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_d   = '0;
`endif

    case (state_q)
      ST_SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (one_low) begin
            row_d   = row_idx;
            state_d = ST_PRESS_DB;
          end else begin
            col_d = next_col;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PRESS_DB: begin
        if (rs == held_pat) begin
          if (cnt_q == DB_LAST) begin
            fire    = 1'b1;
            cnt_d   = '0;
            state_d = ST_HELD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d   = '0;
          col_d   = next_col;
          state_d = ST_SCAN;
        end
      end
      ST_HELD: begin
        if (rs == 4'b1111) begin
          cnt_d   = '0;
          state_d = ST_REL_DB;
        end
`ifdef KEYPAD_REPEAT_EN
        else if (rep_cnt_q == REP_LAST) begin
          fire = (fire_code <= 4'd9);
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
`endif
      end
      ST_REL_DB: begin
        if (rs == 4'b1111) begin
          if (cnt_q == DB_LAST) begin
            cnt_d   = '0;
            col_d   = 2'd0;
            state_d = ST_SCAN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d   = '0;
          state_d = ST_HELD;
        end
      end
      default: state_d = ST_SCAN;
    endcase

    // Digit entry shifts left; star clears, hash only signals enter.
    if (fire) begin
      key_valid_d = 1'b1;
      key_code_d  = fire_code;
      if (fire_code == KEY_STAR) begin
        digits_d = '0;
      end else if (fire_code == KEY_HASH) begin
        enter_d = 1'b1;
      end else begin
        digits_d = {digits_q[11:0], fire_code};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SCAN;
      col_q       <= 2'd0;
      row_q       <= 2'd0;
      cnt_q       <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
      digits_q    <= '0;
      enter_q     <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      digits_q    <= digits_d;
      enter_q     <= enter_d;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q   <= rep_cnt_d;
`endif
    end
  end

  assign col_out   = col_pattern(col_q);
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign digits    = digits_q;
  assign enter     = enter_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl: a behavioural keypad drives the rows from
// col_out, and an event-level model predicts each key event and the BCD preset value.
module tb_keypad_scan_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] digits;
  logic        enter;

  keypad_scan_ctrl #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CYC (8),
    .CNT_W        (8),
    .REPEAT_CYC   (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_valid (key_valid),
    .key_code  (key_code),
    .digits    (digits),
    .enter     (enter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  code;
    logic [15:0] digits;
    logic        enter;
    int          cyc;
  } ev_t;

  typedef struct {
    logic [3:0]  key;
    logic [15:0] exp_digits;
    logic        exp_enter;
  } vec_t;

  ev_t        ev_q[$];
  vec_t       vecs[12];
  logic [3:0] keymap[12];
  logic [11:0] key_down;
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         exp_digits = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural keypad: a held key pulls its row low only while its column is driven.
  always_comb begin
    row_in = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      if (col_out == ~(4'b1000 >> c)) begin
        for (int r = 0; r < 4; r++) begin
          if (key_down[c*4 + r]) row_in[3 - r] = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && key_valid) ev_q.push_back('{key_code, digits, enter, cyc});
    if (!rst && enter && !key_valid) checkOutput("enter_without_valid", {31'b0, key_valid}, 32'd1);
  end

  function automatic int find_key(input logic [3:0] code);
    for (int i = 0; i < 12; i++) if (keymap[i] == code) return i;
    return 0;
  endfunction

  task automatic apply_model(input logic [3:0] code);
    if (code <= 4'd9) exp_digits = (exp_digits * 16 + int'(code)) % 65536;
    else if (code == 4'hA) exp_digits = 0;
  endtask

  // Press one key; total>0 holds it a fixed time, otherwise holds until accepted plus extra.
  task automatic applyStimulus(input logic [3:0] code, input int extra, input int total);
    int waited;
    ev_q.delete();
    key_down = '0;
    key_down[find_key(code)] = 1'b1;
    if (total > 0) begin
      repeat (total) @(negedge clk);
    end else begin
      waited = 0;
      while (ev_q.size() == 0 && waited < 80) begin
        @(negedge clk);
        waited++;
      end
      repeat (extra) @(negedge clk);
    end
    key_down = '0;
    repeat (30) @(negedge clk);
  endtask

  task automatic check_events(input string tag, input logic [3:0] code, input int exact);
    if (exact >= 0) checkOutput({tag, "_count"}, 32'(ev_q.size()), 32'(exact));
    else checkOutput({tag, "_count_min1"}, {31'b0, ev_q.size() > 0}, 32'd1);
    foreach (ev_q[i]) begin
      apply_model(code);
      checkOutput({tag, "_code"}, {28'b0, ev_q[i].code}, {28'b0, code});
      checkOutput({tag, "_digits"}, {16'b0, ev_q[i].digits}, 32'(exp_digits));
      checkOutput({tag, "_enter"}, {31'b0, ev_q[i].enter}, {31'b0, code == 4'hB});
    end
  endtask

  initial begin
    int run;
    int changes;
    logic [3:0] prev_col;
    logic [3:0] rkey;

    keymap = '{4'h1, 4'h4, 4'h7, 4'hA, 4'h2, 4'h5, 4'h8, 4'h0, 4'h3, 4'h6, 4'h9, 4'hB};
    vecs[0]  = '{4'hA, 16'h0000, 1'b0};
    vecs[1]  = '{4'h1, 16'h0001, 1'b0};
    vecs[2]  = '{4'h2, 16'h0012, 1'b0};
    vecs[3]  = '{4'h3, 16'h0123, 1'b0};
    vecs[4]  = '{4'h4, 16'h1234, 1'b0};
    vecs[5]  = '{4'h5, 16'h2345, 1'b0};
    vecs[6]  = '{4'hA, 16'h0000, 1'b0};
    vecs[7]  = '{4'h1, 16'h0001, 1'b0};
    vecs[8]  = '{4'h2, 16'h0012, 1'b0};
    vecs[9]  = '{4'h3, 16'h0123, 1'b0};
    vecs[10] = '{4'h4, 16'h1234, 1'b0};
    vecs[11] = '{4'hB, 16'h1234, 1'b1};

    key_down = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("rst_col_out", {28'b0, col_out}, 32'h7);
    checkOutput("rst_key_valid", {31'b0, key_valid}, 32'd0);
    checkOutput("rst_key_code", {28'b0, key_code}, 32'd0);
    checkOutput("rst_digits", {16'b0, digits}, 32'd0);
    checkOutput("rst_enter", {31'b0, enter}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Key 2 held 40 cycles straight out of reset.
    applyStimulus(4'h2, 0, 40);
`ifdef KEYPAD_REPEAT_EN
    check_events("first", 4'h2, -1);
`else
    check_events("first", 4'h2, 1);
`endif
    if (ev_q.size() > 0) checkOutput("first_digits_abs", {16'b0, ev_q[0].digits}, 32'h0002);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].key, 4, 0);
      check_events("tbl", vecs[i].key, 1);
      if (ev_q.size() > 0) begin
        checkOutput("tbl_digits_abs", {16'b0, ev_q[0].digits}, {16'b0, vecs[i].exp_digits});
        checkOutput("tbl_enter_abs", {31'b0, ev_q[0].enter}, {31'b0, vecs[i].exp_enter});
      end
      checkOutput("tbl_digits_port", {16'b0, digits}, {16'b0, vecs[i].exp_digits});
    end

    // Reset in the middle of press debounce with 0x0042 loaded.
    applyStimulus(4'hA, 2, 0);
    check_events("pre_rst_a", 4'hA, 1);
    applyStimulus(4'h4, 2, 0);
    check_events("pre_rst_4", 4'h4, 1);
    applyStimulus(4'h2, 2, 0);
    check_events("pre_rst_2", 4'h2, 1);
    checkOutput("pre_rst_digits", {16'b0, digits}, 32'h0042);
    ev_q.delete();
    key_down = '0;
    key_down[find_key(4'h8)] = 1'b1;
    run = 0;
    for (int i = 0; i < 100 && run < 6; i++) begin
      @(negedge clk);
      run = (col_out == 4'b1011) ? run + 1 : 0;
    end
    checkOutput("rst_reach_debounce", {31'b0, run >= 6}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_col_out", {28'b0, col_out}, 32'h7);
    checkOutput("midrst_digits", {16'b0, digits}, 32'd0);
    checkOutput("midrst_key_valid", {31'b0, key_valid}, 32'd0);
    key_down = '0;
    exp_digits = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("midrst_no_event", 32'(ev_q.size()), 32'd0);

    // Bouncing key 5: never stable long enough, scanning keeps moving.
    ev_q.delete();
    changes = 0;
    prev_col = col_out;
    for (int k = 0; k < 15; k++) begin
      key_down[5] = 1'b1;
      repeat (3) begin
        @(negedge clk);
        if (col_out != prev_col) changes++;
        prev_col = col_out;
      end
      key_down[5] = 1'b0;
      @(negedge clk);
      if (col_out != prev_col) changes++;
      prev_col = col_out;
    end
    repeat (30) @(negedge clk);
    checkOutput("bounce_no_event", 32'(ev_q.size()), 32'd0);
    checkOutput("bounce_scan_moves", {31'b0, changes >= 3}, 32'd1);

    // Long hold of a digit key, then of star.
    applyStimulus(4'h5, 0, 100);
`ifdef KEYPAD_REPEAT_EN
    check_events("hold5", 4'h5, -1);
    checkOutput("hold5_repeat_min", {31'b0, ev_q.size() >= 4}, 32'd1);
    for (int i = 1; i < ev_q.size(); i++)
      checkOutput("hold5_interval", 32'(ev_q[i].cyc - ev_q[i-1].cyc), 32'd16);
`else
    check_events("hold5", 4'h5, 1);
`endif
    applyStimulus(4'hA, 0, 100);
    check_events("holdA", 4'hA, 1);

    // Two rows low in one column is a ghost and must be ignored.
    ev_q.delete();
    key_down = 12'b0000_0000_0011;
    repeat (60) @(negedge clk);
    key_down = '0;
    repeat (30) @(negedge clk);
    checkOutput("ghost_no_event", 32'(ev_q.size()), 32'd0);

    // Second key in another column while the first is held.
    ev_q.delete();
    key_down = '0;
    key_down[0] = 1'b1;
    run = 0;
    while (ev_q.size() == 0 && run < 80) begin
      @(negedge clk);
      run++;
    end
    key_down[5] = 1'b1;
    repeat (40) @(negedge clk);
    key_down = '0;
    repeat (30) @(negedge clk);
`ifdef KEYPAD_REPEAT_EN
    check_events("second_key", 4'h1, -1);
`else
    check_events("second_key", 4'h1, 1);
`endif

    // Random clean presses against the event-level model.
    for (int n = 0; n < 12; n++) begin
      rkey = keymap[$urandom_range(0, 11)];
      applyStimulus(rkey, int'($urandom_range(0, 6)), 0);
      check_events("rand", rkey, 1);
    end
    checkOutput("rand_digits_port", {16'b0, digits}, 32'(exp_digits));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Sequencer for the 4x3 matrix keypad used for stopwatch/timer entry.
- Drives the column lines one at a time (active-low) and samples the row lines.
- Debounces both press and release, and emits one key event per press.
- Assembles digit keys into a 4-digit BCD preset value that feeds the timer load path.

Parameters:
- SCAN_DIV, 1000: clk cycles each column is driven before its rows are sampled (min 2).
- DEBOUNCE_CYC, 500000: consecutive stable cycles required to accept a press or a release (min 2).
- CNT_W, 20: width of the dwell/debounce counter; must hold max(SCAN_DIV, DEBOUNCE_CYC).
- REPEAT_CYC, 250000: auto-repeat period; used only with KEYPAD_REPEAT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- row_in  in  4  keypad rows, active-low, asynchronous
- col_out  out  4  column drive, active-low one-cold; bit0 unused, held 1
- key_valid  out  1  one-cycle pulse per accepted key
- key_code  out  4  code of the last accepted key: 0-9 = digits, 4'hA = star, 4'hB = hash
- digits  out  16  four BCD digits, [15:12] most significant
- enter  out  1  one-cycle pulse coincident with key_valid when the key is hash

Behaviour:
- Reset values (async): col_out=4'b0111, key_valid=0, key_code=0, digits=0, enter=0, state=SCAN, column=0, counter=0, sync flops=4'b1111.
- Row synchroniser: row_in passes through 2 flops before use; all decisions use the synchronised value rs.
- Column patterns:
  - col0 = 0111
  - col1 = 1011
  - col2 = 1101
- Row decode: rs 0111/1011/1101/1110 = rows 0/1/2/3.
- Key map:
  - col0: rows 0-3 = 1, 4, 7, A
  - col1: rows 0-3 = 2, 5, 8, 0
  - col2: rows 0-3 = 3, 6, 9, B
- FSM states: SCAN, PRESS_DB, HELD, REL_DB.
- SCAN:
  - Counter counts 0..SCAN_DIV-1 with the current column driven.
  - At the terminal count, sample rs. If exactly one row is low, latch column and row, clear the counter, go to PRESS_DB with the column still driven.
  - Otherwise advance the column 0→1→2→0 and clear the counter.
  - rs=1111 or two or more rows low means no key (ghost rejection).
- PRESS_DB:
  - rs equals the latched pattern: counter increments.
  - rs differs: clear the counter, advance the column, return to SCAN.
  - Counter reaches DEBOUNCE_CYC-1: next cycle key_valid=1 and key_code=decoded value, then go to HELD.
- HELD (same column driven): when rs==1111, clear the counter and go to REL_DB.
- REL_DB:
  - rs==1111: counter increments.
  - Any row low: counter cleared, return to HELD.
  - Counter reaches DEBOUNCE_CYC-1: go to SCAN at column 0, counter 0.
- Digit register, updated in the same cycle key_valid asserts:
  - Digit key: digits <= {digits[11:0], code}. The oldest digit is discarded; no overflow flag.
  - A: digits <= 0.
  - B: digits unchanged, enter=1.
- Latency: a clean press is accepted at most 3*SCAN_DIV + DEBOUNCE_CYC + 3 cycles after row_in falls.
- Exactly one key_valid per press regardless of hold time (without the optional feature).
- A second key pressed while one is held: ignored until full release.
- Reset asserted mid-debounce: everything returns to reset values immediately; no pulse is emitted.

Optional Feature:
- Macro KEYPAD_REPEAT_EN.
- Defined: in HELD, a repeat counter runs while the key is held. Every REPEAT_CYC cycles it re-emits key_valid and key_code and re-applies the shift, for digit keys only. A and B never repeat. Leaving HELD clears the repeat counter.
- Undefined: no repeat counter exists; one event per press.

Decomposition:
- Package keypad_pkg holds:
  - column patterns COL0/COL1/COL2
  - key codes KEY_STAR=4'hA and KEY_HASH=4'hB
  - FSM state encoding (2 bits)
  - function decode_key(col, row) returning 4 bits
- One sub-module, keypad_row_sync: 2-flop synchroniser for the 4 rows, reset to 1111.
- FSM, counters and digit register live in the top.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYC=8, REPEAT_CYC=16):
- Hold row_in=0111 only while col_out=1011, held 40 cycles, then release → single key_valid, key_code=2, digits=0x0002.
- Press keys 1, 2, 3, 4, 5 with clean releases → digits 0x0001, 0x0012, 0x0123, 0x1234, 0x2345; then press A → digits=0x0000, key_code=A.
- Press col2/row3 (B) with digits=0x1234 → enter and key_valid high in the same single cycle; digits stays 0x1234.
- Bounce the press (low 3 cycles, high 1 cycle, repeat) → no key_valid; the FSM returns to SCAN each time.
- Hold key 5 for 100 cycles → one pulse without the macro; with KEYPAD_REPEAT_EN, one initial pulse plus one every 16 cycles and digits shifts each time. Holding A with the macro → one pulse only.
- Assert rst during PRESS_DB with digits=0x0042 → next cycle col_out=0111, digits=0, no key_valid. Two rows low (rs=0011) → never accepted.
